// File: rtl/imem_loader_if.sv
// Bus bundle between a program-load controller and the instruction-memory loader:
// byte-stream handshake, instruction-memory write port, core hold and status.
interface imem_loader_if;
  logic        load_start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  // Controller / stream source side
  modport master (
    output load_start, rx_valid, rx_data,
    input  rx_ready, im_we, im_addr, im_wdata, cpu_rst_n, busy, done, error
  );

  // Loader side
  modport slave (
    input  load_start, rx_valid, rx_data,
    output rx_ready, im_we, im_addr, im_wdata, cpu_rst_n, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a 16-bit little-endian word count followed
// by 4*N little-endian instruction bytes and writes them to consecutive word
// addresses from 0, holding the core in reset while memory is rewritten.
// Every output comes straight from a flop; the stream inputs only feed next-state logic.
module imem_loader #(
  parameter int unsigned MAX_WORDS   = 512,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  // The abort fires on the edge where the idle counter would reach TIMEOUT_CYC.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic [15:0]      word_idx_q, word_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      asm_q, asm_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      im_addr_q, im_addr_d;
  logic [31:0]      im_wdata_q, im_wdata_d;
  logic             rx_ready_q, rx_ready_d;
  logic             im_we_q, im_we_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             accept_s;
  logic             tmo_hit_s;
  logic [15:0]      hdr_n_s;

  // rx_ready_q is high exactly in the byte-accepting states, so it doubles as the gate.
  assign accept_s  = bus.rx_valid & rx_ready_q;
  assign tmo_hit_s = (tmo_q == TMO_LAST);

  // Next-state and datapath updates for the load sequence
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    tmo_d      = tmo_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    hdr_n_s    = {bus.rx_data, count_q[7:0]};
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.load_start) begin
          state_d    = S_HDR0;
          word_idx_d = 16'd0;
          byte_idx_d = 2'd0;
          tmo_d      = '0;
        end else begin
          state_d    = state_q;
        end
      end
      S_HDR0: begin
        if (accept_s) begin
          count_d[7:0] = bus.rx_data;
          tmo_d        = '0;
          state_d      = S_HDR1;
        end else if (tmo_hit_s) begin
          state_d      = S_ERR;
        end else begin
          tmo_d        = tmo_q + TMO_W'(1);
        end
      end
      S_HDR1: begin
        if (accept_s) begin
          count_d[15:8] = bus.rx_data;
          tmo_d         = '0;
          if (hdr_n_s == 16'd0) begin
            state_d = S_DONE;
          end else if ({16'd0, hdr_n_s} > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end else if (tmo_hit_s) begin
          state_d = S_ERR;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      S_DATA: begin
        if (accept_s) begin
          asm_d[{byte_idx_q, 3'b000} +: 8] = bus.rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          tmo_d      = '0;
          if (byte_idx_q == 2'd3) begin
            state_d    = S_WRITE;
            im_addr_d  = {14'd0, word_idx_q, 2'b00};
            im_wdata_d = asm_d;
          end else begin
            state_d    = S_DATA;
          end
        end else if (tmo_hit_s) begin
          state_d = S_ERR;
        end else begin
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_d == count_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so outputs move with the state
  always_comb begin
    rx_ready_d  = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
    busy_d      = rx_ready_d || (state_d == S_WRITE);
    im_we_d     = (state_d == S_WRITE);
    cpu_rst_n_d = (state_d == S_IDLE) || (state_d == S_DONE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
  end

  // State, datapath and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= 16'd0;
      word_idx_q  <= 16'd0;
      byte_idx_q  <= 2'd0;
      asm_q       <= 32'd0;
      tmo_q       <= '0;
      im_addr_q   <= 32'd0;
      im_wdata_q  <= 32'd0;
      rx_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      cpu_rst_n_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      tmo_q       <= tmo_d;
      im_addr_q   <= im_addr_d;
      im_wdata_q  <= im_wdata_d;
      rx_ready_q  <= rx_ready_d;
      im_we_q     <= im_we_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.im_we     = im_we_q;
  assign bus.im_addr   = im_addr_q;
  assign bus.im_wdata  = im_wdata_q;
  assign bus.cpu_rst_n = cpu_rst_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader. A short TIMEOUT_CYC keeps the
// abort scenarios quick; MAX_WORDS stays at its default.
module tb_imem_loader;
  localparam int unsigned TMO  = 40;
  localparam int unsigned MAXW = 512;

  logic clk = 1'b0;
  logic rst;
  imem_loader_if bus ();

  imem_loader #(.MAX_WORDS(MAXW), .TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [7:0]  acc_q [$];
  int          viol = 0;

  // Record write pulses, accepted bytes and any write cycle that also offered ready
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.im_we === 1'b1) begin
        wr_addr_q.push_back(bus.im_addr);
        wr_data_q.push_back(bus.im_wdata);
      end
      if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) acc_q.push_back(bus.rx_data);
      if (bus.im_we === 1'b1 && bus.rx_ready === 1'b1) viol++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
  endtask

  // Offer one byte and return just after the edge that accepts it
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    total_cnt++;
    if (n >= 100) $display("FAIL send_byte_wait: byte %h not accepted within %0d cycles", b, n);
    else pass_cnt++;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.load_start = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;
    repeat (3) step();
    total_cnt++;
    if ({bus.im_we, bus.rx_ready, bus.busy, bus.done, bus.error, bus.cpu_rst_n} !== 6'b000001)
      $display("FAIL reset_flags: got %b expected 000001",
               {bus.im_we, bus.rx_ready, bus.busy, bus.done, bus.error, bus.cpu_rst_n});
    else pass_cnt++;
    total_cnt++;
    if (bus.im_addr !== 32'h0 || bus.im_wdata !== 32'h0)
      $display("FAIL reset_bus: got addr=%h wdata=%h expected 0/0", bus.im_addr, bus.im_wdata);
    else pass_cnt++;
    rst = 1'b1;
    repeat (2) step();
    total_cnt++;
    if ({bus.busy, bus.cpu_rst_n, bus.rx_ready} !== 3'b010)
      $display("FAIL idle_after_reset: got %b expected 010", {bus.busy, bus.cpu_rst_n, bus.rx_ready});
    else pass_cnt++;
  endtask

  task automatic test_two_words();
    logic [7:0] s [10];
    int base = wr_addr_q.size();
    s = '{8'h02, 8'h00, 8'h13, 8'h03, 8'h00, 8'h08, 8'h83, 8'h23, 8'h03, 8'h00};
    start_load();
    total_cnt++;
    if ({bus.busy, bus.cpu_rst_n, bus.rx_ready, bus.done, bus.error} !== 5'b10100)
      $display("FAIL hdr0_flags: got %b expected 10100",
               {bus.busy, bus.cpu_rst_n, bus.rx_ready, bus.done, bus.error});
    else pass_cnt++;
    for (int i = 0; i < 10; i++) send_byte(s[i]);
    total_cnt++;
    if (bus.im_we !== 1'b1 || bus.cpu_rst_n !== 1'b0 || bus.rx_ready !== 1'b0 ||
        bus.im_addr !== 32'h4 || bus.im_wdata !== 32'h00032383)
      $display("FAIL write1: got we=%b crn=%b rdy=%b addr=%h data=%h expected 1 0 0 4 00032383",
               bus.im_we, bus.cpu_rst_n, bus.rx_ready, bus.im_addr, bus.im_wdata);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({bus.done, bus.cpu_rst_n, bus.busy, bus.im_we, bus.error} !== 5'b11000)
      $display("FAIL done_entry: got %b expected 11000",
               {bus.done, bus.cpu_rst_n, bus.busy, bus.im_we, bus.error});
    else pass_cnt++;
    total_cnt++;
    if (bus.im_addr !== 32'h4 || bus.im_wdata !== 32'h00032383)
      $display("FAIL bus_hold: got addr=%h data=%h expected 4 00032383", bus.im_addr, bus.im_wdata);
    else pass_cnt++;
    total_cnt++;
    if (wr_addr_q.size() - base != 2 || wr_addr_q[base] !== 32'h0 || wr_data_q[base] !== 32'h08000313 ||
        wr_addr_q[base+1] !== 32'h4 || wr_data_q[base+1] !== 32'h00032383)
      $display("FAIL two_word_writes: got n=%0d a0=%h d0=%h a1=%h d1=%h expected 2 0 08000313 4 00032383",
               wr_addr_q.size() - base, wr_addr_q[base], wr_data_q[base], wr_addr_q[base+1], wr_data_q[base+1]);
    else pass_cnt++;
  endtask

  task automatic test_zero_count();
    int base = wr_addr_q.size();
    start_load();
    total_cnt++;
    if ({bus.done, bus.error, bus.busy, bus.cpu_rst_n} !== 4'b0010)
      $display("FAIL zero_hdr0: got %b expected 0010", {bus.done, bus.error, bus.busy, bus.cpu_rst_n});
    else pass_cnt++;
    send_byte(8'h00);
    total_cnt++;
    if ({bus.busy, bus.cpu_rst_n} !== 2'b10)
      $display("FAIL zero_hdr1: got %b expected 10", {bus.busy, bus.cpu_rst_n});
    else pass_cnt++;
    send_byte(8'h00);
    total_cnt++;
    if ({bus.done, bus.cpu_rst_n, bus.busy, bus.error} !== 4'b1100)
      $display("FAIL zero_done: got %b expected 1100", {bus.done, bus.cpu_rst_n, bus.busy, bus.error});
    else pass_cnt++;
    step();
    total_cnt++;
    if (wr_addr_q.size() != base)
      $display("FAIL zero_writes: got %0d expected 0", wr_addr_q.size() - base);
    else pass_cnt++;
  endtask

  task automatic test_too_many();
    int base = wr_addr_q.size();
    start_load();
    send_byte(8'h01);
    send_byte(8'h02);
    total_cnt++;
    if ({bus.error, bus.done, bus.busy, bus.cpu_rst_n, bus.rx_ready} !== 5'b10000)
      $display("FAIL n513_err: got %b expected 10000",
               {bus.error, bus.done, bus.busy, bus.cpu_rst_n, bus.rx_ready});
    else pass_cnt++;
    repeat (5) step();
    total_cnt++;
    if (bus.error !== 1'b1 || bus.cpu_rst_n !== 1'b0 || wr_addr_q.size() != base)
      $display("FAIL n513_hold: got err=%b crn=%b writes=%0d expected 1 0 0",
               bus.error, bus.cpu_rst_n, wr_addr_q.size() - base);
    else pass_cnt++;
  endtask

  task automatic test_max_words();
    int base = wr_addr_q.size();
    logic [31:0] w;
    start_load();
    send_byte(8'h00);
    send_byte(8'h02);
    for (int i = 0; i < 512; i++) begin
      w = 32'hC000_003C | (32'(i) << 8);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    end
    step();
    total_cnt++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0)
      $display("FAIL n512_done: got done=%b err=%b expected 1 0", bus.done, bus.error);
    else pass_cnt++;
    total_cnt++;
    if (wr_addr_q.size() - base != 512 || wr_addr_q[base+511] !== 32'h7FC || wr_data_q[base+511] !== 32'hC001_FF3C)
      $display("FAIL n512_last: got n=%0d addr=%h data=%h expected 512 7fc c001ff3c",
               wr_addr_q.size() - base, wr_addr_q[base+511], wr_data_q[base+511]);
    else pass_cnt++;
    total_cnt++;
    if (wr_addr_q[base+100] !== 32'h190 || wr_data_q[base+100] !== 32'hC000_643C)
      $display("FAIL n512_mid: got addr=%h data=%h expected 190 c000643c",
               wr_addr_q[base+100], wr_data_q[base+100]);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int base = wr_addr_q.size();
    int n = 0;
    start_load();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    while (bus.error !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    total_cnt++;
    if (n != TMO) $display("FAIL timeout_cycles: got %0d expected %0d", n, TMO);
    else pass_cnt++;
    total_cnt++;
    if ({bus.busy, bus.cpu_rst_n, bus.done} !== 3'b000)
      $display("FAIL timeout_flags: got %b expected 000", {bus.busy, bus.cpu_rst_n, bus.done});
    else pass_cnt++;
    total_cnt++;
    if (wr_addr_q.size() - base != 1 || wr_addr_q[base] !== 32'h0 || wr_data_q[base] !== 32'h44332211)
      $display("FAIL timeout_writes: got n=%0d addr=%h data=%h expected 1 0 44332211",
               wr_addr_q.size() - base, wr_addr_q[base], wr_data_q[base]);
    else pass_cnt++;
  endtask

  task automatic test_byte_wins();
    int base = wr_addr_q.size();
    start_load();
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (TMO - 1) step();
    send_byte(8'hAA);
    total_cnt++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL byte_wins: got err=%b busy=%b expected 0 1", bus.error, bus.busy);
    else pass_cnt++;
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    step();
    total_cnt++;
    if (bus.done !== 1'b1 || wr_addr_q.size() - base != 1 || wr_data_q[base] !== 32'hDDCCBBAA)
      $display("FAIL byte_wins_word: got done=%b n=%0d data=%h expected 1 1 ddccbbaa",
               bus.done, wr_addr_q.size() - base, wr_data_q[base]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int base;
    start_load();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    send_byte(8'h06);
    base = wr_addr_q.size();
    rst = 1'b0;
    #2;
    total_cnt++;
    if ({bus.im_we, bus.rx_ready, bus.busy, bus.done, bus.error, bus.cpu_rst_n} !== 6'b000001 ||
        bus.im_addr !== 32'h0 || bus.im_wdata !== 32'h0)
      $display("FAIL midreset_outputs: got flags=%b addr=%h data=%h expected 000001 0 0",
               {bus.im_we, bus.rx_ready, bus.busy, bus.done, bus.error, bus.cpu_rst_n},
               bus.im_addr, bus.im_wdata);
    else pass_cnt++;
    repeat (2) step();
    rst = 1'b1;
    repeat (4) step();
    total_cnt++;
    if (wr_addr_q.size() != base || bus.busy !== 1'b0 || bus.cpu_rst_n !== 1'b1)
      $display("FAIL midreset_idle: got writes=%0d busy=%b crn=%b expected 0 0 1",
               wr_addr_q.size() - base, bus.busy, bus.cpu_rst_n);
    else pass_cnt++;
    start_load();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h0D);
    send_byte(8'h0C);
    send_byte(8'h0B);
    send_byte(8'h0A);
    total_cnt++;
    if (bus.im_we !== 1'b1 || bus.im_addr !== 32'h0 || bus.im_wdata !== 32'h0A0B0C0D)
      $display("FAIL reload_write: got we=%b addr=%h data=%h expected 1 0 0a0b0c0d",
               bus.im_we, bus.im_addr, bus.im_wdata);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.done !== 1'b1) $display("FAIL reload_done: got %b expected 1", bus.done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [14];
    int wbase = wr_addr_q.size();
    int abase = acc_q.size();
    int v0 = viol;
    int idx = 0;
    int guard = 0;
    int bad = 0;
    s = '{8'h03, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23,
          8'h30, 8'h31, 8'h32, 8'h33};
    start_load();
    bus.rx_valid = 1'b1;
    while (idx < 14 && guard < 100) begin
      bus.rx_data = s[idx];
      if (bus.rx_ready === 1'b1) idx++;
      step();
      guard++;
    end
    bus.rx_valid = 1'b0;
    step();
    for (int i = 0; i < 14; i++) if (acc_q[abase+i] !== s[i]) bad++;
    total_cnt++;
    if (acc_q.size() - abase != 14 || bad != 0)
      $display("FAIL b2b_bytes: got %0d bytes with %0d wrong expected 14 with 0 wrong",
               acc_q.size() - abase, bad);
    else pass_cnt++;
    total_cnt++;
    if (viol != v0) $display("FAIL b2b_ready_in_write: got %0d expected 0", viol - v0);
    else pass_cnt++;
    total_cnt++;
    if (wr_addr_q.size() - wbase != 3 || wr_data_q[wbase] !== 32'h13121110 ||
        wr_data_q[wbase+1] !== 32'h23222120 || wr_data_q[wbase+2] !== 32'h33323130 ||
        wr_addr_q[wbase+2] !== 32'h8)
      $display("FAIL b2b_writes: got n=%0d d0=%h d1=%h d2=%h a2=%h expected 3 13121110 23222120 33323130 8",
               wr_addr_q.size() - wbase, wr_data_q[wbase], wr_data_q[wbase+1], wr_data_q[wbase+2],
               wr_addr_q[wbase+2]);
    else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b1) $display("FAIL b2b_done: got %b expected 1", bus.done);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_two_words();
    test_zero_count();
    test_too_many();
    test_max_words();
    test_timeout();
    test_byte_wins();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
